// File: rtl/gat_debug_monitor.sv
// Debug monitor for the GAT pipeline: sticky stage flags, per-stage latency/event
// counters, address-matched data capture and a registered word-indexed readout.
module gat_debug_monitor #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned NUM_CAP    = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned CAP_W      = 32,
    parameter logic [31:0] BUILD_ID   = 32'd15160504,
    parameter int unsigned RD_SEL_W   = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic [NUM_STAGES-1:0]       stage_vld_i,
    input  logic [NUM_STAGES-1:0]       stage_rdy_i,
    input  logic [ADDR_W-1:0]           mon_addr_i,
    input  logic                        mon_en_i,
    input  logic [CAP_W-1:0]            cap_data_i,
    input  logic [NUM_CAP*ADDR_W-1:0]   cfg_cap_addr_i,
    input  logic [NUM_CAP-1:0]          cfg_cap_first_i,
    input  logic [RD_SEL_W-1:0]         rd_sel_i,
    output logic [31:0]                 rd_data_o,
    output logic [2*NUM_STAGES-1:0]     flags_o
);

    localparam int unsigned    LAT_BASE = 4;
    localparam int unsigned    EVT_BASE = LAT_BASE + NUM_STAGES;
    localparam int unsigned    CAP_BASE = EVT_BASE + NUM_STAGES;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stage_st_e;

    stage_st_e             st_q  [NUM_STAGES];
    logic [CNT_W-1:0]      lat_q [NUM_STAGES];
    logic [CNT_W-1:0]      evt_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] vld_seen_q;
    logic [NUM_STAGES-1:0] rdy_seen_q;
    logic [CAP_W-1:0]      cap_q [NUM_CAP];
    logic [NUM_CAP-1:0]    hit_q;
    logic [NUM_CAP-1:0]    match_c;
    logic [31:0]           rd_data_q;
    logic [31:0]           rd_data_d;
    logic [31:0]           sel_c;
    logic                  clr_c;

    // Reset and clear are indistinguishable in effect.
    assign clr_c = !rst_n || clr_i;

    // Per-stage start-to-finish latency FSM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (clr_c) begin
                st_q[i]  <= ST_IDLE;
                lat_q[i] <= '0;
            end else begin
                case (st_q[i])
                    ST_IDLE: begin
                        if (stage_vld_i[i]) begin
                            st_q[i]  <= stage_rdy_i[i] ? ST_DONE : ST_RUN;
                            lat_q[i] <= stage_rdy_i[i] ? '0 : CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (stage_rdy_i[i]) begin
                            st_q[i] <= ST_DONE;
                        end else if (lat_q[i] != CNT_MAX) begin
                            lat_q[i] <= lat_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        st_q[i] <= st_q[i];
                    end
                endcase
            end
        end
    end

    // Sticky flags and saturating valid-cycle counters.
    always_ff @(posedge clk) begin
        if (clr_c) begin
            vld_seen_q <= '0;
            rdy_seen_q <= '0;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                evt_q[i] <= '0;
            end
        end else begin
            vld_seen_q <= vld_seen_q | stage_vld_i;
            rdy_seen_q <= rdy_seen_q | stage_rdy_i;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                if (stage_vld_i[i] && (evt_q[i] != CNT_MAX)) begin
                    evt_q[i] <= evt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        match_c = '0;
        for (int j = 0; j < int'(NUM_CAP); j++) begin
            match_c[j] = mon_en_i && (mon_addr_i == cfg_cap_addr_i[j*ADDR_W +: ADDR_W]);
        end
    end

    // Capture slots: first-match slots freeze once hit, others track the latest match.
    always_ff @(posedge clk) begin
        if (clr_c) begin
            hit_q <= '0;
            for (int j = 0; j < int'(NUM_CAP); j++) begin
                cap_q[j] <= '0;
            end
        end else begin
            hit_q <= hit_q | match_c;
            for (int j = 0; j < int'(NUM_CAP); j++) begin
                if (match_c[j] && (!cfg_cap_first_i[j] || !hit_q[j])) begin
                    cap_q[j] <= cap_data_i;
                end
            end
        end
    end

    // Stage 0 sits in the top pair; vld is the upper bit of each pair.
    always_comb begin
        flags_o = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            flags_o[2*(NUM_STAGES-1-i)+1] = vld_seen_q[i];
            flags_o[2*(NUM_STAGES-1-i)]   = rdy_seen_q[i];
        end
    end

    assign sel_c = 32'(rd_sel_i);

    // Readout word map; unmapped indices read as zero.
    always_comb begin
        rd_data_d = '0;
        if (sel_c == 32'd0) begin
            rd_data_d = BUILD_ID;
        end else if (sel_c == 32'd1) begin
            rd_data_d = 32'(flags_o);
        end else if (sel_c == 32'd2) begin
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                rd_data_d[i] = (st_q[i] == ST_DONE);
            end
            for (int j = 0; j < int'(NUM_CAP); j++) begin
                rd_data_d[16+j] = hit_q[j];
            end
        end else if (sel_c == 32'd3) begin
            rd_data_d = {16'd0, 8'(NUM_CAP), 8'(NUM_STAGES)};
        end else begin
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                if (sel_c == 32'(LAT_BASE + 32'(i))) begin
                    rd_data_d = 32'(lat_q[i]);
                end
                if (sel_c == 32'(EVT_BASE + 32'(i))) begin
                    rd_data_d = 32'(evt_q[i]);
                end
            end
            for (int j = 0; j < int'(NUM_CAP); j++) begin
                if (sel_c == 32'(CAP_BASE + 32'(j))) begin
                    rd_data_d = 32'(cap_q[j]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_c) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_gat_debug_monitor.sv
// Self-checking bench for gat_debug_monitor: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a timestamp model.
module tb_gat_debug_monitor;

    localparam int unsigned NS     = 4;
    localparam int unsigned NC     = 2;
    localparam int unsigned CW     = 4;
    localparam int unsigned AW     = 14;
    localparam int unsigned DW     = 32;
    localparam int unsigned SW     = 6;
    localparam logic [31:0] BID    = 32'd15160504;
    localparam longint      MAXC   = (longint'(1) << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_i;
    logic [NS-1:0]     stage_vld_i;
    logic [NS-1:0]     stage_rdy_i;
    logic [AW-1:0]     mon_addr_i;
    logic              mon_en_i;
    logic [DW-1:0]     cap_data_i;
    logic [NC*AW-1:0]  cfg_cap_addr_i;
    logic [NC-1:0]     cfg_cap_first_i;
    logic [SW-1:0]     rd_sel_i;
    logic [31:0]       rd_data_o;
    logic [2*NS-1:0]   flags_o;

    gat_debug_monitor #(
        .NUM_STAGES(NS), .NUM_CAP(NC), .CNT_W(CW), .ADDR_W(AW),
        .CAP_W(DW), .BUILD_ID(BID), .RD_SEL_W(SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_i           (clr_i),
        .stage_vld_i     (stage_vld_i),
        .stage_rdy_i     (stage_rdy_i),
        .mon_addr_i      (mon_addr_i),
        .mon_en_i        (mon_en_i),
        .cap_data_i      (cap_data_i),
        .cfg_cap_addr_i  (cfg_cap_addr_i),
        .cfg_cap_first_i (cfg_cap_first_i),
        .rd_sel_i        (rd_sel_i),
        .rd_data_o       (rd_data_o),
        .flags_o         (flags_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Model: a stage is described by when it started and when it finished.
    longint      cyc = 0;
    bit          m_run   [NS];
    bit          m_done  [NS];
    longint      m_start [NS];
    longint      m_fin   [NS];
    longint      m_evt   [NS];
    bit          m_vs    [NS];
    bit          m_rs    [NS];
    bit          m_hit   [NC];
    logic [31:0] m_cap   [NC];
    logic [31:0] exp_rd;
    logic [7:0]  exp_flags;
    bit          model_ok = 1'b0;

    function automatic logic [31:0] sat(input longint v);
        return 32'((v > MAXC) ? MAXC : v);
    endfunction

    function automatic logic [31:0] lat_of(input int i);
        if (m_done[i]) return sat(m_fin[i] - m_start[i]);
        if (m_run[i])  return sat(cyc - m_start[i]);
        return 32'd0;
    endfunction

    function automatic logic [7:0] flags_model();
        logic [7:0] f = '0;
        for (int i = 0; i < int'(NS); i++) begin
            f[2*(int'(NS)-1-i)+1] = m_vs[i];
            f[2*(int'(NS)-1-i)]   = m_rs[i];
        end
        return f;
    endfunction

    function automatic logic [31:0] rd_model(input int sel);
        logic [31:0] r = '0;
        if (sel == 0) return BID;
        if (sel == 1) return 32'(flags_model());
        if (sel == 2) begin
            for (int i = 0; i < int'(NS); i++) r[i] = m_done[i];
            for (int j = 0; j < int'(NC); j++) r[16+j] = m_hit[j];
            return r;
        end
        if (sel == 3) return 32'(NS) | (32'(NC) << 8);
        if (sel >= 4 && sel < 4 + int'(NS)) return lat_of(sel - 4);
        if (sel >= 4 + int'(NS) && sel < 4 + 2*int'(NS)) return sat(m_evt[sel - 4 - int'(NS)]);
        if (sel >= 4 + 2*int'(NS) && sel < 4 + 2*int'(NS) + int'(NC)) return m_cap[sel - 4 - 2*int'(NS)];
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || clr_i) begin
            exp_rd = '0;
            for (int i = 0; i < int'(NS); i++) begin
                m_run[i] = 0; m_done[i] = 0; m_start[i] = 0; m_fin[i] = 0;
                m_evt[i] = 0; m_vs[i] = 0; m_rs[i] = 0;
            end
            for (int j = 0; j < int'(NC); j++) begin
                m_hit[j] = 0; m_cap[j] = '0;
            end
        end else begin
            exp_rd = rd_model(int'(rd_sel_i));
            for (int i = 0; i < int'(NS); i++) begin
                if (stage_vld_i[i]) begin m_vs[i] = 1; m_evt[i]++; end
                if (stage_rdy_i[i]) m_rs[i] = 1;
                if (!m_run[i] && !m_done[i] && stage_vld_i[i]) begin
                    m_start[i] = cyc;
                    if (stage_rdy_i[i]) begin m_done[i] = 1; m_fin[i] = cyc; end
                    else m_run[i] = 1;
                end else if (m_run[i] && stage_rdy_i[i]) begin
                    m_run[i] = 0; m_done[i] = 1; m_fin[i] = cyc;
                end
            end
            for (int j = 0; j < int'(NC); j++) begin
                if (mon_en_i && mon_addr_i == cfg_cap_addr_i[j*AW +: AW]) begin
                    if (!cfg_cap_first_i[j] || !m_hit[j]) m_cap[j] = cap_data_i;
                    m_hit[j] = 1;
                end
            end
        end
        exp_flags = flags_model();
        model_ok  = 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("rd_data_model", rd_data_o, exp_rd);
            check("flags_model", 32'(flags_o), 32'(exp_flags));
        end
    end

    task automatic idle();
        clr_i = 0; stage_vld_i = '0; stage_rdy_i = '0; mon_en_i = 0;
    endtask

    task automatic read_lit(input int sel, input logic [31:0] exp, input string name);
        idle();
        rd_sel_i = SW'(sel);
        @(negedge clk);
        check(name, rd_data_o, exp);
    endtask

    task automatic capture_pair();
        mon_en_i = 1; mon_addr_i = AW'(10); cap_data_i = 32'hA; @(negedge clk);
        cap_data_i = 32'hB; @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 0; idle(); rd_sel_i = '0; mon_addr_i = '0; cap_data_i = '0;
        cfg_cap_addr_i = {14'd20, 14'd10}; cfg_cap_first_i = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_rd", rd_data_o, 32'd0);
        check("reset_flags", 32'(flags_o), 32'd0);
        rst_n = 1;

        stage_vld_i = 4'b0001; @(negedge clk); idle();
        repeat (6) @(negedge clk);
        stage_rdy_i = 4'b0001; @(negedge clk);
        read_lit(4, 32'd7, "lat0_k7");
        check("flags_stage0", 32'(flags_o), 32'h0000_00C0);
        read_lit(2, 32'd1, "done_stage0");

        stage_vld_i = 4'b0010; stage_rdy_i = 4'b0010; @(negedge clk); idle();
        repeat (2) @(negedge clk);
        stage_vld_i = 4'b0010; @(negedge clk); idle();
        stage_rdy_i = 4'b0010; @(negedge clk);
        read_lit(5, 32'd0, "lat1_same_cycle");
        read_lit(9, 32'd2, "evt1_two");
        read_lit(2, 32'd3, "done_stage01");

        stage_vld_i = 4'b0100; @(negedge clk); idle();
        repeat (20) @(negedge clk);
        read_lit(6, 32'd15, "lat2_saturate");
        stage_vld_i = 4'b0100; repeat (20) @(negedge clk); idle();
        read_lit(10, 32'd15, "evt2_saturate");

        capture_pair();
        read_lit(12, 32'hB, "cap0_last");
        read_lit(13, 32'd0, "cap1_untouched");
        read_lit(2, 32'h0001_0003, "hit0_done01");
        clr_i = 1; @(negedge clk); idle();
        cfg_cap_first_i = 2'b01;
        capture_pair();
        read_lit(12, 32'hA, "cap0_first");
        read_lit(2, 32'h0001_0000, "hit0_after_clr");

        clr_i = 1; @(negedge clk); idle();
        stage_vld_i = 4'b1000; @(negedge clk); idle();
        repeat (4) @(negedge clk);
        read_lit(7, 32'd5, "lat3_running");
        clr_i = 1; @(negedge clk); idle();
        read_lit(7, 32'd0, "lat3_cleared");
        read_lit(11, 32'd0, "evt3_cleared");
        read_lit(12, 32'd0, "cap0_cleared");
        read_lit(2, 32'd0, "status_cleared");
        check("flags_cleared", 32'(flags_o), 32'd0);
        stage_rdy_i = 4'b1000; @(negedge clk); idle();
        read_lit(7, 32'd0, "lat3_no_restart");
        read_lit(2, 32'd0, "done3_not_set");
        check("flags_rdy3", 32'(flags_o), 32'd1);

        read_lit(0, BID, "build_id");
        read_lit(3, 32'h0000_0204, "geometry");
        read_lit(63, 32'd0, "out_of_range");
        rd_sel_i = '0; rst_n = 0; @(negedge clk);
        check("reset_mid_rd", rd_data_o, 32'd0);
        rst_n = 1;

        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) cfg_cap_addr_i = {14'd10, 14'd10};
            if ($urandom_range(0, 199) == 0) cfg_cap_first_i = 2'($urandom);
            rst_n       = ($urandom_range(0, 499) != 0);
            clr_i       = ($urandom_range(0, 149) == 0);
            stage_vld_i = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            stage_rdy_i = ($urandom_range(0, 4) == 0) ? NS'($urandom) : '0;
            mon_en_i    = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       mon_addr_i = AW'(10);
                1:       mon_addr_i = AW'(20);
                default: mon_addr_i = AW'($urandom);
            endcase
            cap_data_i  = $urandom;
            rd_sel_i    = ($urandom_range(0, 9) == 0) ? SW'($urandom) : SW'($urandom_range(0, 13));
            @(negedge clk);
        end
        idle(); rst_n = 1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
